// File: rtl/fewcore_pkg.sv
// Shared definitions for the fewcore pipeline memory stage.
// Contents:
//   OPC_LOAD / OPC_STORE       - opcode classes handled by the memory stage
//   F3_*                       - funct3 access-size encodings
//   mem_state_t                - memory stage FSM states (IDLE, WAIT)
//   acc_size_t                 - resolved access size (byte, half, word)
//   codeOpcode / codeFunct3    - field slices of the 12-bit code bundle
//   accessSize / isMisaligned  - size resolution and alignment rule
package fewcore_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // code = {2'b0, funct3[2:0], opcode[6:0]}
    localparam int CODE_OPC_LSB = 0;
    localparam int CODE_OPC_W   = 7;
    localparam int CODE_F3_LSB  = 7;
    localparam int CODE_F3_W    = 3;

    typedef enum logic { IDLE = 1'b0, WAIT = 1'b1 } mem_state_t;

    typedef enum logic [1:0] { SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2 } acc_size_t;

    function automatic logic [6:0] codeOpcode(input logic [11:0] codeVal);
        return codeVal[CODE_OPC_LSB +: CODE_OPC_W];
    endfunction

    function automatic logic [2:0] codeFunct3(input logic [11:0] codeVal);
        return codeVal[CODE_F3_LSB +: CODE_F3_W];
    endfunction

    // Stores only know B/H/W, so the unsigned encodings fall back to a word
    // for them, as does every unknown funct3 for either direction.
    function automatic acc_size_t accessSize(input logic isStore, input logic [2:0] funct3);
        acc_size_t size;
        case (funct3)
            F3_B:    size = SZ_B;
            F3_H:    size = SZ_H;
            F3_BU:   if (isStore) size = SZ_W; else size = SZ_B;
            F3_HU:   if (isStore) size = SZ_W; else size = SZ_H;
            default: size = SZ_W;
        endcase
        return size;
    endfunction

    function automatic logic isMisaligned(input acc_size_t size, input logic [1:0] addrLow);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = addrLow[0];
            default: mis = (addrLow != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic for data-memory accesses.
// Ports:
//   isStore   in   access is a store (selects store size rules)
//   funct3    in   access size / signedness
//   addrLow   in   effective address bits [1:0]
//   storeData in   rs2 value to be written
//   rdata     in   word read from memory
//   byteEn    out  store byte lanes
//   wdata     out  store data replicated into lanes
//   loadData  out  selected and extended load result
module load_store_align
    import fewcore_pkg::*;
(
    input  logic        isStore,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLow,
    input  logic [31:0] storeData,
    input  logic [31:0] rdata,
    output logic [3:0]  byteEn,
    output logic [31:0] wdata,
    output logic [31:0] loadData
);

    acc_size_t   size_s;
    logic [7:0]  lane_byte_s;
    logic [15:0] lane_half_s;

    // Store lane enables/replication and load byte/half selection with extension.
    always_comb begin
        size_s      = accessSize(isStore, funct3);
        byteEn      = 4'b0000;
        wdata       = 32'h0000_0000;
        loadData    = 32'h0000_0000;
        lane_byte_s = rdata[{addrLow, 3'b000} +: 8];
        if (addrLow[1]) begin
            lane_half_s = rdata[31:16];
        end else begin
            lane_half_s = rdata[15:0];
        end

        case (size_s)
            SZ_B: begin
                byteEn = 4'b0001 << addrLow;
                wdata  = {4{storeData[7:0]}};
            end
            SZ_H: begin
                byteEn = 4'b0011 << addrLow;
                wdata  = {2{storeData[15:0]}};
            end
            default: begin
                byteEn = 4'b1111;
                wdata  = storeData;
            end
        endcase

        case (funct3)
            F3_B:    loadData = {{24{lane_byte_s[7]}}, lane_byte_s};
            F3_BU:   loadData = {24'h00_0000, lane_byte_s};
            F3_H:    loadData = {{16{lane_half_s[15]}}, lane_half_s};
            F3_HU:   loadData = {16'h0000, lane_half_s};
            F3_W:    loadData = rdata;
            default: loadData = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage of the fewcore pipeline: passes ALU results through and runs
// data-memory loads/stores over a req/ready handshake, stalling upstream
// while an access is outstanding.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   inValid .. storeData       instruction bundle from execute
//   stall                      upstream must hold its inputs
//   memReq/memWe/memAddr/
//   memByteEn/memWData         request to data memory (held while waiting)
//   memRData, memReady         response from data memory
//   outValid .. misaligned     registered bundle for the write stage
module mem_access
    import fewcore_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              inValid,
    input  logic              writeEnabledIn,
    input  logic [11:0]       codeIn,
    input  logic [4:0]        rdIn,
    input  logic [XLEN-1:0]   aluResult,
    input  logic [XLEN-1:0]   storeData,
    output logic              stall,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [3:0]        memByteEn,
    output logic [XLEN-1:0]   memWData,
    input  logic [XLEN-1:0]   memRData,
    input  logic              memReady,
    output logic              outValid,
    output logic              writeEnabled,
    output logic [11:0]       code,
    output logic [4:0]        rd,
    output logic [XLEN-1:0]   dataAlu,
    output logic [XLEN-1:0]   memAddress,
    output logic              misaligned
);

    mem_state_t        state_r;
    mem_state_t        next_state_s;

    logic [2:0]        in_f3_s;
    logic              in_is_store_s;
    logic              in_is_mem_s;
    logic              in_mis_s;
    logic              pend_is_store_s;

    logic              al_is_store_s;
    logic [2:0]        al_f3_s;
    logic [1:0]        al_addr_low_s;
    logic [3:0]        al_byte_en_s;
    logic [XLEN-1:0]   al_wdata_s;
    logic [XLEN-1:0]   al_load_data_s;

    logic [11:0]       pend_code_r;
    logic [4:0]        pend_rd_r;
    logic              pend_we_r;
    logic [XLEN-1:0]   pend_addr_r;

    logic              stall_r;
    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [3:0]        mem_byte_en_r;
    logic [XLEN-1:0]   mem_wdata_r;
    logic              out_valid_r;
    logic              write_enabled_r;
    logic [11:0]       code_r;
    logic [4:0]        rd_r;
    logic [XLEN-1:0]   data_alu_r;
    logic [XLEN-1:0]   mem_address_r;
    logic              misaligned_r;

    // Decode the incoming instruction and steer the shared lane logic: new
    // inputs while idle, the latched access while waiting for memory.
    always_comb begin
        in_f3_s         = codeFunct3(codeIn);
        in_is_store_s   = (codeOpcode(codeIn) == OPC_STORE);
        in_is_mem_s     = (codeOpcode(codeIn) == OPC_LOAD) | in_is_store_s;
        in_mis_s        = in_is_mem_s &
                          isMisaligned(accessSize(in_is_store_s, in_f3_s), aluResult[1:0]);
        pend_is_store_s = (codeOpcode(pend_code_r) == OPC_STORE);
        if (state_r == WAIT) begin
            al_is_store_s = pend_is_store_s;
            al_f3_s       = codeFunct3(pend_code_r);
            al_addr_low_s = pend_addr_r[1:0];
        end else begin
            al_is_store_s = in_is_store_s;
            al_f3_s       = in_f3_s;
            al_addr_low_s = aluResult[1:0];
        end
    end

    load_store_align u_align (
        .isStore   (al_is_store_s),
        .funct3    (al_f3_s),
        .addrLow   (al_addr_low_s),
        .storeData (storeData),
        .rdata     (memRData),
        .byteEn    (al_byte_en_s),
        .wdata     (al_wdata_s),
        .loadData  (al_load_data_s)
    );

    // Next-state logic: only aligned loads/stores leave IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (inValid && in_is_mem_s && !in_mis_s) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                if (memReady) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = WAIT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request, pending-access and output bundle registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_code_r     <= 12'h000;
            pend_rd_r       <= 5'd0;
            pend_we_r       <= 1'b0;
            pend_addr_r     <= '0;
            stall_r         <= 1'b0;
            mem_req_r       <= 1'b0;
            mem_we_r        <= 1'b0;
            mem_addr_r      <= '0;
            mem_byte_en_r   <= 4'b0000;
            mem_wdata_r     <= '0;
            out_valid_r     <= 1'b0;
            write_enabled_r <= 1'b0;
            code_r          <= 12'h000;
            rd_r            <= 5'd0;
            data_alu_r      <= '0;
            mem_address_r   <= '0;
            misaligned_r    <= 1'b0;
        end else begin
            out_valid_r  <= 1'b0;
            misaligned_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (inValid) begin
                        if (!in_is_mem_s) begin
                            out_valid_r     <= 1'b1;
                            write_enabled_r <= writeEnabledIn;
                            code_r          <= codeIn;
                            rd_r            <= rdIn;
                            data_alu_r      <= aluResult;
                            mem_address_r   <= aluResult;
                        end else if (in_mis_s) begin
                            // Reported without touching memory; nothing is written back.
                            out_valid_r     <= 1'b1;
                            misaligned_r    <= 1'b1;
                            write_enabled_r <= 1'b0;
                            code_r          <= codeIn;
                            rd_r            <= rdIn;
                            data_alu_r      <= aluResult;
                            mem_address_r   <= aluResult;
                        end else begin
                            pend_code_r   <= codeIn;
                            pend_rd_r     <= rdIn;
                            pend_we_r     <= writeEnabledIn;
                            pend_addr_r   <= aluResult;
                            stall_r       <= 1'b1;
                            mem_req_r     <= 1'b1;
                            mem_we_r      <= in_is_store_s;
                            mem_addr_r    <= {aluResult[ADDR_W-1:2], 2'b00};
                            mem_byte_en_r <= al_byte_en_s;
                            mem_wdata_r   <= al_wdata_s;
                        end
                    end
                end
                WAIT: begin
                    if (memReady) begin
                        stall_r       <= 1'b0;
                        mem_req_r     <= 1'b0;
                        out_valid_r   <= 1'b1;
                        code_r        <= pend_code_r;
                        rd_r          <= pend_rd_r;
                        mem_address_r <= pend_addr_r;
                        if (pend_is_store_s) begin
                            write_enabled_r <= 1'b0;
                            data_alu_r      <= pend_addr_r;
                        end else begin
                            write_enabled_r <= pend_we_r;
                            data_alu_r      <= al_load_data_s;
                        end
                    end
                end
                default: begin
                    stall_r   <= 1'b0;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    assign stall        = stall_r;
    assign memReq       = mem_req_r;
    assign memWe        = mem_we_r;
    assign memAddr      = mem_addr_r;
    assign memByteEn    = mem_byte_en_r;
    assign memWData     = mem_wdata_r;
    assign outValid     = out_valid_r;
    assign writeEnabled = write_enabled_r;
    assign code         = code_r;
    assign rd           = rd_r;
    assign dataAlu      = data_alu_r;
    assign memAddress   = mem_address_r;
    assign misaligned   = misaligned_r;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: the driver pushes expected write-stage
// bundles computed from a byte-level memory model; a monitor pops and
// compares on every outValid; a memory responder checks requests and
// answers with random latency from its own word array.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        reset;
    logic        inValid;
    logic        writeEnabledIn;
    logic [11:0] codeIn;
    logic [4:0]  rdIn;
    logic [31:0] aluResult;
    logic [31:0] storeData;
    logic        stall;
    logic        memReq;
    logic        memWe;
    logic [31:0] memAddr;
    logic [3:0]  memByteEn;
    logic [31:0] memWData;
    logic [31:0] memRData;
    logic        memReady;
    logic        outValid;
    logic        writeEnabled;
    logic [11:0] code;
    logic [4:0]  rd;
    logic [31:0] dataAlu;
    logic [31:0] memAddress;
    logic        misaligned;

    mem_access #(.ADDR_W(32), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .writeEnabledIn(writeEnabledIn),
        .codeIn(codeIn), .rdIn(rdIn), .aluResult(aluResult), .storeData(storeData),
        .stall(stall), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memByteEn(memByteEn), .memWData(memWData), .memRData(memRData),
        .memReady(memReady), .outValid(outValid), .writeEnabled(writeEnabled),
        .code(code), .rd(rd), .dataAlu(dataAlu), .memAddress(memAddress),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADD   = 7'b0110011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [11:0] code;
        logic [31:0] data;
        logic [31:0] addr;
        logic        mis;
        bit          chkData;
        bit          chkMeta;
    } exp_t;

    exp_t        expQ[$];
    int          validTimes[$];
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;

    logic [7:0]  refMem [0:255];
    logic [31:0] mem [0:63];

    // responder control and expectations for the outstanding request
    bit          autoRespond = 1'b1;
    logic        autoReady = 1'b0;
    logic        manualReady = 1'b0;
    int          forcedDelay = -1;
    int          curDelay = 0;
    int          waitCnt = 0;
    logic [31:0] expMemAddr;
    logic        expWe;
    logic [3:0]  expByteEn;
    logic [31:0] expWData;
    logic        capWe;
    logic [31:0] capAddr;
    logic [3:0]  capBe;
    logic [31:0] capWd;

    assign memReady = autoRespond ? autoReady : manualReady;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, expv, cycle);
        end
    endtask

    function automatic logic [31:0] laneMask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Monitor: every outValid pulse must match the oldest expected bundle.
    always @(negedge clk) begin
        exp_t e;
        if (outValid) begin
            validTimes.push_back(cycle);
            if (expQ.size() == 0) begin
                chk("unexpected_outValid", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                chk("writeEnabled", {31'd0, writeEnabled}, {31'd0, e.we});
                chk("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
                if (e.chkMeta) begin
                    chk("rd", {27'd0, rd}, {27'd0, e.rd});
                    chk("code", {20'd0, code}, {20'd0, e.code});
                    chk("memAddress", memAddress, e.addr);
                end
                if (e.chkData) chk("dataAlu", dataAlu, e.data);
            end
        end else begin
            chk("misaligned_without_outValid", {31'd0, misaligned}, 32'd0);
        end
    end

    // Memory responder: checks the request and its stability, answers after a delay.
    always @(negedge clk) begin
        autoReady = 1'b0;
        memRData  = $urandom;
        if (memReq) begin
            if (waitCnt == 0) begin
                curDelay = (forcedDelay >= 0) ? forcedDelay : int'($urandom_range(0, 3));
                chk("memAddr", memAddr, expMemAddr);
                chk("memWe", {31'd0, memWe}, {31'd0, expWe});
                if (expWe) begin
                    chk("memByteEn", {28'd0, memByteEn}, {28'd0, expByteEn});
                    chk("memWData", memWData & laneMask(expByteEn), expWData);
                end
                capWe = memWe; capAddr = memAddr; capBe = memByteEn; capWd = memWData;
            end else begin
                chk("req_stable", {memWe, memByteEn, memAddr[26:0]}, {capWe, capBe, capAddr[26:0]});
                chk("wdata_stable", memWData, capWd);
            end
            if (waitCnt >= curDelay) begin
                autoReady = 1'b1;
                memRData  = mem[memAddr[7:2]];
                if (memWe && autoRespond) begin
                    for (int i = 0; i < 4; i++)
                        if (memByteEn[i]) mem[memAddr[7:2]][8*i +: 8] = memWData[8*i +: 8];
                end
                waitCnt = 0;
            end else begin
                waitCnt++;
            end
        end else begin
            waitCnt = 0;
        end
    end

    // Present one instruction at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rdv,
                         input logic wev, input logic [31:0] alu, input logic [31:0] sd,
                         input bit expectOut);
        exp_t e;
        int sz, bound, off;
        bit isL, isS, mis;
        logic [7:0] a;
        codeIn = {2'b00, f3, opc}; rdIn = rdv; writeEnabledIn = wev;
        aluResult = alu; storeData = sd; inValid = 1'b1;
        bound = 0;
        while (stall && bound < 200) begin @(negedge clk); bound++; end
        if (stall) chk("accept_timeout", 32'd1, 32'd0);
        isL = (opc == OP_LOAD); isS = (opc == OP_STORE);
        if (isS) sz = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else     sz = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        a   = alu[7:0];
        off = int'(alu[1:0]);
        mis = (isL || isS) && ((sz == 2 && alu[0]) || (sz == 4 && alu[1:0] != 2'b00));
        e.rd = rdv; e.code = {2'b00, f3, opc}; e.addr = alu; e.mis = 1'b0;
        e.chkMeta = 1'b1; e.chkData = 1'b0; e.data = 32'd0; e.we = 1'b0;
        if (!isL && !isS) begin
            e.we = wev; e.data = alu; e.chkData = 1'b1;
        end else if (mis) begin
            e.mis = 1'b1; e.chkMeta = 1'b0;
        end else begin
            expMemAddr = {alu[31:2], 2'b00};
            expWe = isS; expByteEn = 4'b0000; expWData = 32'd0;
            if (isS) begin
                for (int i = 0; i < 4; i++)
                    if (i >= off && i < off + sz) begin
                        expByteEn[i] = 1'b1;
                        expWData[8*i +: 8] = sd[8*(i-off) +: 8];
                    end
                for (int i = 0; i < sz; i++) refMem[a + 8'(i)] = sd[8*i +: 8];
            end else begin
                e.we = wev; e.chkData = 1'b1;
                if (sz == 1)
                    e.data = (f3 == 3'd0) ? {{24{refMem[a][7]}}, refMem[a]} : {24'd0, refMem[a]};
                else if (sz == 2)
                    e.data = (f3 == 3'd1) ? {{16{refMem[a+8'd1][7]}}, refMem[a+8'd1], refMem[a]}
                                          : {16'd0, refMem[a+8'd1], refMem[a]};
                else
                    e.data = {refMem[a+8'd3], refMem[a+8'd2], refMem[a+8'd1], refMem[a]};
            end
        end
        if (expectOut) expQ.push_back(e);
        @(posedge clk);
        @(negedge clk);
        inValid = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] w;
        logic [6:0] opc;
        logic [31:0] addr;
        for (int i = 0; i < 64; i++) begin
            w = $urandom;
            if (i == 0) w = 32'h80FF_0000;
            mem[i] = w;
            for (int b = 0; b < 4; b++) refMem[4*i + b] = w[8*b +: 8];
        end
        reset = 1'b1; inValid = 1'b0; writeEnabledIn = 1'b0; codeIn = 12'd0;
        rdIn = 5'd0; aluResult = 32'd0; storeData = 32'd0;
        repeat (3) @(negedge clk);
        chk("reset_outValid", {31'd0, outValid}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        chk("reset_memReq", {31'd0, memReq}, 32'd0);
        chk("reset_writeEnabled", {31'd0, writeEnabled}, 32'd0);
        chk("reset_misaligned", {31'd0, misaligned}, 32'd0);
        chk("reset_dataAlu", dataAlu, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // ADD pass-through: one-cycle latency, no stall
        issue(OP_ADD, 3'd0, 5'd5, 1'b1, 32'h0000_1234, 32'd0, 1'b1);
        chk("add_latency_outValid", {31'd0, outValid}, 32'd1);
        chk("add_dataAlu", dataAlu, 32'h0000_1234);
        chk("add_stall", {31'd0, stall}, 32'd0);

        // LB / LBU at 0x103 with three wait cycles
        forcedDelay = 2;
        issue(OP_LOAD, 3'b000, 5'd9, 1'b1, 32'h0000_0103, 32'd0, 1'b1);
        n = 0;
        while (stall && n < 100) begin n++; @(negedge clk); end
        chk("lb_stall_cycles", n, 32'd3);
        chk("lb_dataAlu", dataAlu, 32'hFFFF_FF80);
        issue(OP_LOAD, 3'b100, 5'd9, 1'b1, 32'h0000_0103, 32'd0, 1'b1);
        n = 0;
        while (stall && n < 100) begin n++; @(negedge clk); end
        chk("lbu_dataAlu", dataAlu, 32'h0000_0080);

        // SH at 0x22
        forcedDelay = 1;
        issue(OP_STORE, 3'b001, 5'd3, 1'b1, 32'h0000_0022, 32'hDEAD_BEEF, 1'b1);
        chk("sh_memByteEn", {28'd0, memByteEn}, 32'h0000_000C);
        chk("sh_memWData", memWData, 32'hBEEF_BEEF);

        // LW at 0x6: misaligned, no request
        issue(OP_LOAD, 3'b010, 5'd4, 1'b1, 32'h0000_0006, 32'd0, 1'b1);
        chk("lw_mis_memReq", {31'd0, memReq}, 32'd0);
        chk("lw_mis_pulse", {30'd0, outValid, misaligned}, 32'd3);

        // reset during WAIT of an LW; a late memReady is ignored
        autoRespond = 1'b0;
        issue(OP_LOAD, 3'b010, 5'd6, 1'b1, 32'h0000_0040, 32'd0, 1'b0);
        chk("rst_wait_memReq", {31'd0, memReq}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_memReq", {31'd0, memReq}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_outValid", {31'd0, outValid}, 32'd0);
        reset = 1'b0; manualReady = 1'b1;
        @(negedge clk);
        manualReady = 1'b0;
        chk("late_ready_outValid", {31'd0, outValid}, 32'd0);
        chk("late_ready_memReq", {31'd0, memReq}, 32'd0);
        autoRespond = 1'b1;
        issue(OP_ADD, 3'd0, 5'd7, 1'b1, 32'h0000_0777, 32'd0, 1'b1);

        // back-to-back SW/LW at 0x40 with immediate memReady
        forcedDelay = 0;
        issue(OP_STORE, 3'b010, 5'd1, 1'b0, 32'h0000_0040, 32'hCAFE_F00D, 1'b1);
        issue(OP_LOAD, 3'b010, 5'd2, 1'b1, 32'h0000_0040, 32'd0, 1'b1);
        repeat (4) @(negedge clk);
        if (validTimes.size() >= 2)
            chk("b2b_spacing", validTimes[validTimes.size()-1] - validTimes[validTimes.size()-2], 32'd2);
        else
            chk("b2b_pulses", validTimes.size(), 32'd2);
        chk("b2b_load_data", dataAlu, 32'hCAFE_F00D);

        // randomized mix
        forcedDelay = -1;
        for (int t = 0; t < 300; t++) begin
            case ($urandom_range(0, 2))
                0:       opc = ($urandom_range(0, 1) != 0) ? OP_ADD : OP_ADDI;
                1:       opc = OP_LOAD;
                default: opc = OP_STORE;
            endcase
            addr = {24'd0, 8'($urandom_range(0, 255))};
            if ($urandom_range(0, 1) != 0) addr[1:0] = 2'b00;
            issue(opc, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), addr, $urandom, 1'b1);
        end

        n = 0;
        while (expQ.size() != 0 && n < 200) begin n++; @(negedge clk); end
        chk("drain_queue_empty", expQ.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
